// File: rtl/align_shift_seq_if.sv
// ============================================================================
// align_shift_seq_if : valid/ready operand and result bundle for align_shift_seq
// Rev 1.0
// ============================================================================
`default_nettype none

interface align_shift_seq_if #(
   parameter int MANTIS_SIZE = 27,
   parameter int EXP_SIZE    = 8
) ();
   logic                   in_valid;
   logic                   in_ready;
   logic [EXP_SIZE-1:0]    exp_in;
   logic [EXP_SIZE-1:0]    exp_target;
   logic [MANTIS_SIZE-1:0] mantis_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [EXP_SIZE-1:0]    exp_out;
   logic [MANTIS_SIZE-1:0] mantis_out;
   logic                   out_bad;

   modport master (
      output in_valid, exp_in, exp_target, mantis_in, out_ready,
      input  in_ready, out_valid, exp_out, mantis_out, out_bad
   );

   modport slave (
      input  in_valid, exp_in, exp_target, mantis_in, out_ready,
      output in_ready, out_valid, exp_out, mantis_out, out_bad
   );
endinterface

`default_nettype wire

// File: rtl/align_shift_seq.sv
// ============================================================================
// align_shift_seq : iterative 1-bit/cycle right-shift aligner with sticky LSB
// Rev 1.0
// ============================================================================
`default_nettype none

module align_shift_seq #(
   parameter int MANTIS_SIZE = 27,
   parameter int EXP_SIZE    = 8
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   align_shift_seq_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [EXP_SIZE-1:0]    count_q, count_d;
   logic [EXP_SIZE-1:0]    exp_q,   exp_d;
   logic [MANTIS_SIZE-1:0] mant_q,  mant_d;
   logic                   bad_q,   bad_d;

   logic                   target_ge;
   logic [EXP_SIZE-1:0]    diff;
   logic                   collapse;

   assign target_ge = (bus.exp_target >= bus.exp_in);
   assign diff      = bus.exp_target - bus.exp_in;
   // A remaining shift of the full width or more leaves only the sticky bit.
   assign collapse  = (32'(count_q) >= 32'(MANTIS_SIZE));

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      exp_d   = exp_q;
      mant_d  = mant_q;
      bad_d   = bad_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               mant_d = bus.mantis_in;
               if (target_ge) begin
                  count_d = diff;
                  exp_d   = bus.exp_target;
                  bad_d   = 1'b0;
                  state_d = (diff != '0) ? S_SHIFT : S_DONE;
               end else begin
                  count_d = '0;
                  exp_d   = bus.exp_in;
                  bad_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            if (collapse) begin
               mant_d  = {{(MANTIS_SIZE-1){1'b0}}, |mant_q};
               count_d = '0;
               state_d = S_DONE;
            end else begin
               mant_d  = {1'b0, mant_q[MANTIS_SIZE-1:2], mant_q[1] | mant_q[0]};
               count_d = count_q - EXP_SIZE'(1);
               if (count_q == EXP_SIZE'(1)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         exp_q   <= '0;
         mant_q  <= '0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         exp_q   <= exp_d;
         mant_q  <= mant_d;
         bad_q   <= bad_d;
      end
   end

   assign bus.in_ready   = (state_q == S_IDLE);
   assign bus.out_valid  = (state_q == S_DONE);
   assign bus.exp_out    = exp_q;
   assign bus.mantis_out = mant_q;
   assign bus.out_bad    = bad_q;
endmodule

`default_nettype wire

// File: tb/tb_align_shift_seq.sv
// ============================================================================
// tb_align_shift_seq : vector table + scoreboard bench for align_shift_seq
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_align_shift_seq;
   localparam int MS = 8;
   localparam int ES = 5;

   typedef struct {
      logic [ES-1:0] ei;
      logic [ES-1:0] et;
      logic [MS-1:0] m;
      logic [MS-1:0] em;
      logic [ES-1:0] ee;
      logic          eb;
      int            lat;
   } vec_t;

   typedef struct {
      logic [MS-1:0] em;
      logic [ES-1:0] ee;
      logic          eb;
      int            lat;
      int            acc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   exp_t sb[$];
   exp_t e_cur;
   int   first_c = 0;
   logic pv = 1'b0;
   vec_t tv[16];

   align_shift_seq_if #(.MANTIS_SIZE(MS), .EXP_SIZE(ES)) bus ();

   align_shift_seq #(.MANTIS_SIZE(MS), .EXP_SIZE(ES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [ES-1:0] ei, input logic [ES-1:0] et,
                       input logic [MS-1:0] m, input logic [MS-1:0] em,
                       input logic [ES-1:0] ee, input logic eb, input int lat);
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
         return;
      end
      bus.exp_in     = ei;
      bus.exp_target = et;
      bus.mantis_in  = m;
      bus.in_valid   = 1'b1;
      sb.push_back('{em, ee, eb, lat, cyc + 1});
      @(negedge clk);
      bus.in_valid   = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   // Result monitor: sampled 1ns after the falling edge, away from both edges.
   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         pv = 1'b0;
      end else begin
         if (bus.out_valid && !pv) first_c = cyc;
         pv = bus.out_valid;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
               e_cur = sb.pop_front();
               chk("mantis_out", 32'(bus.mantis_out), 32'(e_cur.em));
               chk("exp_out",    32'(bus.exp_out),    32'(e_cur.ee));
               chk("out_bad",    32'(bus.out_bad),    32'(e_cur.eb));
               chk("latency",    32'(first_c - e_cur.acc + 1), 32'(e_cur.lat));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.in_valid   = 1'b0;
      bus.exp_in     = '0;
      bus.exp_target = '0;
      bus.mantis_in  = '0;
      bus.out_ready  = 1'b1;

      //          ei     et     m      em     ee     eb    lat
      tv[0]  = '{5'd3,  5'd3,  8'hB4, 8'hB4, 5'd3,  1'b0, 1};
      tv[1]  = '{5'd2,  5'd5,  8'hB5, 8'h17, 5'd5,  1'b0, 4};
      tv[2]  = '{5'd0,  5'd20, 8'h80, 8'h01, 5'd20, 1'b0, 2};
      tv[3]  = '{5'd0,  5'd20, 8'h00, 8'h00, 5'd20, 1'b0, 2};
      tv[4]  = '{5'd7,  5'd4,  8'h9C, 8'h9C, 5'd7,  1'b1, 1};
      tv[5]  = '{5'd0,  5'd1,  8'hFF, 8'h7F, 5'd1,  1'b0, 2};
      tv[6]  = '{5'd0,  5'd7,  8'hFF, 8'h01, 5'd7,  1'b0, 8};
      tv[7]  = '{5'd0,  5'd8,  8'hFF, 8'h01, 5'd8,  1'b0, 2};
      tv[8]  = '{5'd5,  5'd6,  8'h81, 8'h41, 5'd6,  1'b0, 2};
      tv[9]  = '{5'd1,  5'd3,  8'hC0, 8'h30, 5'd3,  1'b0, 3};
      tv[10] = '{5'd10, 5'd13, 8'hB8, 8'h17, 5'd13, 1'b0, 4};
      tv[11] = '{5'd0,  5'd7,  8'h40, 8'h01, 5'd7,  1'b0, 8};
      tv[12] = '{5'd31, 5'd0,  8'h55, 8'h55, 5'd31, 1'b1, 1};
      tv[13] = '{5'd4,  5'd10, 8'h02, 8'h01, 5'd10, 1'b0, 7};
      tv[14] = '{5'd0,  5'd31, 8'hAA, 8'h01, 5'd31, 1'b0, 2};
      tv[15] = '{5'd2,  5'd4,  8'h03, 8'h01, 5'd4,  1'b0, 3};

      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
      chk("rst_mantis_out", 32'(bus.mantis_out), 32'd0);
      chk("rst_exp_out",    32'(bus.exp_out),    32'd0);
      chk("rst_out_bad",    32'(bus.out_bad),    32'd0);
      chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         send(tv[i].ei, tv[i].et, tv[i].m, tv[i].em, tv[i].ee, tv[i].eb, tv[i].lat);
      end
      drain();

      // Back-pressure: result held in DONE, a stray in_valid pulse is ignored.
      bus.out_ready = 1'b0;
      send(5'd2, 5'd5, 8'hB5, 8'h17, 5'd5, 1'b0, 4);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("stall_valid_seen", 32'(bus.out_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid",    32'(bus.out_valid),  32'd1);
         chk("stall_mantis",   32'(bus.mantis_out), 32'h17);
         chk("stall_exp",      32'(bus.exp_out),    32'd5);
         chk("stall_bad",      32'(bus.out_bad),    32'd0);
         chk("stall_in_ready", 32'(bus.in_ready),   32'd0);
         if (k == 1) begin
            bus.exp_in     = 5'd0;
            bus.exp_target = 5'd3;
            bus.mantis_in  = 8'hFF;
            bus.in_valid   = 1'b1;
         end else begin
            bus.in_valid   = 1'b0;
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("release_valid",    32'(bus.out_valid), 32'd0);
      chk("release_in_ready", 32'(bus.in_ready),  32'd1);
      chk("release_mantis",   32'(bus.mantis_out), 32'h17);
      drain();

      // Asynchronous reset in the middle of a 7-step shift.
      send(5'd0, 5'd7, 8'hFF, 8'h01, 5'd7, 1'b0, 8);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid",  32'(bus.out_valid),  32'd0);
      chk("abort_mantis_out", 32'(bus.mantis_out), 32'd0);
      chk("abort_exp_out",    32'(bus.exp_out),    32'd0);
      chk("abort_out_bad",    32'(bus.out_bad),    32'd0);
      chk("abort_in_ready",   32'(bus.in_ready),   32'd1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      send(5'd4, 5'd5, 8'h03, 8'h01, 5'd5, 1'b0, 2);
      drain();

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
